// File: rtl/unidade_execucao.sv
// -----------------------------------------------------------------------------
// unidade_execucao -- execute stage of the datapath.
//
// Sits downstream of the 16x32 register file. On an accepted start it
// computes an ALU result in one cycle and drives the register file write
// port with it. MUL is a 32-iteration shift-add that holds busy while it
// runs. Zero/carry flags are registered for the branch logic.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-low reset
//   start           instruction valid, sampled only while busy = 0
//   opcode[3:0]     operation select
//   add_dest[3:0]   destination register address
//   operand_a       register file read port 1
//   operand_b       register file read port 2
//   use_imm         1: B comes from sign-extended imm instead of operand_b
//   imm[15:0]       immediate
//   busy            multicycle op in progress, start ignored
//   add_reg_write   register file write address (holds after the write)
//   data_reg_write  register file write data (holds after the write)
//   enable_write    register file write enable, one-cycle pulse
//   flag_zero       last completed result was zero
//   flag_carry      carry/borrow of the last ADD/SUB/CMP, else 0
// -----------------------------------------------------------------------------
module unidade_execucao #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [3:0]       add_dest,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             use_imm,
  input  logic [15:0]      imm,
  output logic             busy,
  output logic [3:0]       add_reg_write,
  output logic [WIDTH-1:0] data_reg_write,
  output logic             enable_write,
  output logic             flag_zero,
  output logic             flag_carry
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [3:0]       dest_q, dest_d;
  logic [3:0]       waddr_d;
  logic [WIDTH-1:0] wdata_d;
  logic             we_d, zero_d, carry_d;

  // Operand B and the full-width add/sub; bit WIDTH is carry-out for the
  // sum and borrow (A < B unsigned) for the difference.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_w, diff_w;

  assign b_eff  = use_imm ? {{(WIDTH-16){imm[15]}}, imm} : operand_b;
  assign sum_w  = {1'b0, operand_a} + {1'b0, b_eff};
  assign diff_w = {1'b0, operand_a} - {1'b0, b_eff};

  // Single-cycle ALU: result, carry, and whether the op writes / sets flags.
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_write, alu_flags;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_write = 1'b1;
    alu_flags = 1'b1;
    unique case (opcode)
      OP_ADD: begin alu_res = sum_w[WIDTH-1:0];  alu_carry = sum_w[WIDTH];  end
      OP_SUB: begin alu_res = diff_w[WIDTH-1:0]; alu_carry = diff_w[WIDTH]; end
      OP_AND: alu_res = operand_a & b_eff;
      OP_OR:  alu_res = operand_a | b_eff;
      OP_XOR: alu_res = operand_a ^ b_eff;
      OP_SHL: alu_res = operand_a << b_eff[4:0];
      OP_SHR: alu_res = operand_a >> b_eff[4:0];
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(b_eff))};
      OP_MOV: alu_res = b_eff;
      OP_CMP: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
        alu_write = 1'b0;
      end
      default: begin  // MUL is handled by the FSM; 11-15 are NOPs
        alu_write = 1'b0;
        alu_flags = 1'b0;
      end
    endcase
  end

  // Next-state and next-register logic.
  logic [WIDTH-1:0] acc_step;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    we_d     = 1'b0;
    waddr_d  = add_reg_write;
    wdata_d  = data_reg_write;
    zero_d   = flag_zero;
    carry_d  = flag_carry;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (opcode == OP_MUL) begin
            // Operands are captured here so later register file writes
            // cannot disturb the product.
            state_d  = MUL;
            mcand_d  = operand_a;
            mplier_d = b_eff;
            acc_d    = '0;
            cnt_d    = '0;
            dest_d   = add_dest;
          end else begin
            if (alu_write) begin
              we_d    = 1'b1;
              waddr_d = add_dest;
              wdata_d = alu_res;
            end
            if (alu_flags) begin
              zero_d  = (alu_res == '0);
              carry_d = alu_carry;
            end
          end
        end
      end
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        // The 32nd iteration and the write share an edge, so the written
        // value is this cycle's step, not the stored accumulator.
        if (cnt_q == LAST_ITER) begin
          state_d = IDLE;
          we_d    = 1'b1;
          waddr_d = dest_q;
          wdata_d = acc_step;
          zero_d  = (acc_step == '0);
          carry_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous -- rst is only looked at on the clock edge,
    // and every register, datapath included, is cleared so a MUL in flight
    // is fully abandoned.
    if (!rst) begin
      state_q        <= IDLE;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      dest_q         <= '0;
      enable_write   <= 1'b0;
      add_reg_write  <= '0;
      data_reg_write <= '0;
      flag_zero      <= 1'b0;
      flag_carry     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge.
      state_q        <= state_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      dest_q         <= dest_d;
      enable_write   <= we_d;
      add_reg_write  <= waddr_d;
      data_reg_write <= wdata_d;
      flag_zero      <= zero_d;
      flag_carry     <= carry_d;
    end
  end

  assign busy = (state_q == MUL);

endmodule

// File: tb/tb_unidade_execucao.sv
// -----------------------------------------------------------------------------
// tb_unidade_execucao -- directed bench for unidade_execucao.
// Inputs change 1 time unit after a rising edge; outputs are compared at the
// same point, i.e. they show the effect of the edge just taken.
// -----------------------------------------------------------------------------
module tb_unidade_execucao;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  opcode;
  logic [3:0]  add_dest;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        use_imm;
  logic [15:0] imm;
  logic        busy;
  logic [3:0]  add_reg_write;
  logic [31:0] data_reg_write;
  logic        enable_write;
  logic        flag_zero;
  logic        flag_carry;

  int checks = 0;
  int errors = 0;

  unidade_execucao #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .opcode         (opcode),
    .add_dest       (add_dest),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .use_imm        (use_imm),
    .imm            (imm),
    .busy           (busy),
    .add_reg_write  (add_reg_write),
    .data_reg_write (data_reg_write),
    .enable_write   (enable_write),
    .flag_zero      (flag_zero),
    .flag_carry     (flag_carry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] dest,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ui, input logic [15:0] im);
    start     = 1'b1;
    opcode    = op;
    add_dest  = dest;
    operand_a = a;
    operand_b = b;
    use_imm   = ui;
    imm       = im;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; opcode = 4'd0; add_dest = 4'd0;
    operand_a = '0; operand_b = '0; use_imm = 1'b0; imm = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (enable_write !== 1'b0) begin errors++; $display("FAIL reset_we got %0h exp 0", enable_write); end
    checks++; if (add_reg_write !== 4'd0) begin errors++; $display("FAIL reset_addr got %0h exp 0", add_reg_write); end
    checks++; if (data_reg_write !== 32'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", data_reg_write); end
    checks++; if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {flag_zero, flag_carry}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_add();
    issue(4'd0, 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 16'h0);
    tick();
    start = 1'b0;
    checks++; if (enable_write !== 1'b1) begin errors++; $display("FAIL add_we got %0h exp 1", enable_write); end
    checks++; if (add_reg_write !== 4'd3) begin errors++; $display("FAIL add_addr got %0h exp 3", add_reg_write); end
    checks++; if (data_reg_write !== 32'd0) begin errors++; $display("FAIL add_data got %0h exp 0", data_reg_write); end
    checks++; if ({flag_zero, flag_carry} !== 2'b11) begin errors++; $display("FAIL add_flags got %b exp 11", {flag_zero, flag_carry}); end
    tick();
    checks++; if (enable_write !== 1'b0) begin errors++; $display("FAIL add_we_pulse got %0h exp 0", enable_write); end
    checks++; if ({add_reg_write, data_reg_write} !== {4'd3, 32'd0}) begin errors++; $display("FAIL add_hold got %0h/%0h exp 3/0", add_reg_write, data_reg_write); end
  endtask

  task automatic test_sub_cmp();
    issue(4'd1, 4'd4, 32'd5, 32'h1234_5678, 1'b1, 16'hFFFF);
    tick();
    checks++; if ({enable_write, add_reg_write} !== {1'b1, 4'd4}) begin errors++; $display("FAIL sub_write got %0h/%0h exp 1/4", enable_write, add_reg_write); end
    checks++; if (data_reg_write !== 32'd6) begin errors++; $display("FAIL sub_data got %0h exp 6", data_reg_write); end
    checks++; if ({flag_zero, flag_carry} !== 2'b01) begin errors++; $display("FAIL sub_flags got %b exp 01", {flag_zero, flag_carry}); end
    issue(4'd10, 4'd6, 32'd7, 32'd7, 1'b0, 16'h0);
    tick();
    start = 1'b0;
    checks++; if (enable_write !== 1'b0) begin errors++; $display("FAIL cmp_we got %0h exp 0", enable_write); end
    checks++; if ({add_reg_write, data_reg_write} !== {4'd4, 32'd6}) begin errors++; $display("FAIL cmp_hold got %0h/%0h exp 4/6", add_reg_write, data_reg_write); end
    checks++; if ({flag_zero, flag_carry} !== 2'b10) begin errors++; $display("FAIL cmp_flags got %b exp 10", {flag_zero, flag_carry}); end
    tick();
  endtask

  task automatic test_mul();
    issue(4'd8, 4'd9, 32'h0001_2345, 32'h0000_0100, 1'b0, 16'h0);
    tick();  // edge E
    checks++; if ({busy, enable_write} !== 2'b10) begin errors++; $display("FAIL mul_start got busy/we %b exp 10", {busy, enable_write}); end
    // Change operands and opcode so late starts would be visible ADD writes
    // and any dependence on live operands would corrupt the product.
    start = 1'b0; opcode = 4'd0; add_dest = 4'd1; operand_a = 32'd1; operand_b = 32'd1;
    for (int k = 1; k <= 32; k++) begin
      start = (k == 11 || k == 32);
      tick();  // edge E+k
      if (k < 32) begin
        checks++;
        if ({busy, enable_write} !== 2'b10) begin
          errors++; $display("FAIL mul_busy_e%0d got busy/we %b exp 10", k, {busy, enable_write});
        end
      end
    end
    start = 1'b0;
    checks++; if ({busy, enable_write} !== 2'b01) begin errors++; $display("FAIL mul_done got busy/we %b exp 01", {busy, enable_write}); end
    checks++; if (add_reg_write !== 4'd9) begin errors++; $display("FAIL mul_addr got %0h exp 9", add_reg_write); end
    checks++; if (data_reg_write !== 32'h0123_4500) begin errors++; $display("FAIL mul_data got %0h exp 01234500", data_reg_write); end
    checks++; if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL mul_flags got %b exp 00", {flag_zero, flag_carry}); end
    tick();  // edge E+33: the start at E+32 must not have been taken
    checks++; if ({busy, enable_write} !== 2'b00) begin errors++; $display("FAIL mul_ignored_start got busy/we %b exp 00", {busy, enable_write}); end
    checks++; if ({add_reg_write, data_reg_write} !== {4'd9, 32'h0123_4500}) begin errors++; $display("FAIL mul_hold got %0h/%0h", add_reg_write, data_reg_write); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops   [6] = '{4'd3, 4'd5, 4'd7, 4'd6, 4'd6, 4'd9};
    logic [31:0] as    [6] = '{32'hF0F0_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd0};
    logic [31:0] bs    [6] = '{32'h0000_0F0F, 32'd31, 32'd0, 32'd0, 32'd4, 32'd0};
    logic        uis   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] ims   [6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0004, 16'h8000};
    logic [31:0] exps  [6] = '{32'hF0F0_0F0F, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'h0800_0000, 32'hFFFF_8000};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], 4'(i + 10), as[i], bs[i], uis[i], ims[i]);
      tick();
      checks++;
      if ({enable_write, add_reg_write, data_reg_write} !== {1'b1, 4'(i + 10), exps[i]}) begin
        errors++;
        $display("FAIL b2b_%0d got we=%0h addr=%0h data=%0h exp we=1 addr=%0h data=%0h",
                 i, enable_write, add_reg_write, data_reg_write, 4'(i + 10), exps[i]);
      end
    end
    start = 1'b0;
    tick();
    checks++; if (enable_write !== 1'b0) begin errors++; $display("FAIL b2b_end_we got %0h exp 0", enable_write); end
    checks++; if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL b2b_flags got %b exp 00", {flag_zero, flag_carry}); end
  endtask

  task automatic test_reset_mid_mul();
    issue(4'd8, 4'd7, 32'd3, 32'd5, 1'b0, 16'h0);
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if ({busy, enable_write} !== 2'b00) begin errors++; $display("FAIL rstmul_state got busy/we %b exp 00", {busy, enable_write}); end
    checks++; if (data_reg_write !== 32'd0) begin errors++; $display("FAIL rstmul_data got %0h exp 0", data_reg_write); end
    for (int k = 0; k < 25; k++) begin
      tick();
      checks++;
      if ({busy, enable_write} !== 2'b00) begin
        errors++; $display("FAIL rstmul_quiet_%0d got busy/we %b exp 00", k, {busy, enable_write});
      end
    end
    issue(4'd0, 4'd5, 32'd2, 32'd2, 1'b0, 16'h0);
    tick();
    start = 1'b0;
    checks++;
    if ({enable_write, add_reg_write, data_reg_write} !== {1'b1, 4'd5, 32'd4}) begin
      errors++; $display("FAIL rstmul_add got we=%0h addr=%0h data=%0h exp 1/5/4", enable_write, add_reg_write, data_reg_write);
    end
  endtask

  task automatic test_nop();
    issue(4'd0, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 16'h0);
    tick();
    issue(4'd12, 4'd8, 32'd9, 32'd9, 1'b0, 16'h0);
    tick();
    start = 1'b0;
    checks++; if (enable_write !== 1'b0) begin errors++; $display("FAIL nop_we got %0h exp 0", enable_write); end
    checks++; if ({flag_zero, flag_carry} !== 2'b11) begin errors++; $display("FAIL nop_flags got %b exp 11", {flag_zero, flag_carry}); end
    checks++; if ({add_reg_write, data_reg_write} !== {4'd2, 32'd0}) begin errors++; $display("FAIL nop_hold got %0h/%0h exp 2/0", add_reg_write, data_reg_write); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_nop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
